// File: rtl/rll_key_loader.sv
// rll_key_loader: byte-serial key loader for random-logic-locked netlists.
// Collects NBYTES key bytes plus an XOR checksum byte over a valid/ready
// stream and commits the key to key_out only when the checksum matches.
module rll_key_loader #(
    parameter int KEY_WIDTH = 32,
    parameter int TIMEOUT   = 255,
    parameter bit ONE_SHOT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 key_clear,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 key_loaded,
    output logic                 key_error,
    output logic                 locked
);

    localparam int NBYTES = KEY_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHK    = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           acc_q, acc_d;
    logic [15:0]          tmo_q, tmo_d;
    logic [KEY_WIDTH-1:0] stage_q, stage_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_loaded_q, key_loaded_d;
    logic                 key_error_q, key_error_d;
    logic                 accept;

    // Ready depends only on state and key_clear, never on s_valid.
    assign s_ready = (state_q != S_LOCKED) && !key_clear;
    assign accept  = s_valid && s_ready;

    // Next-state and datapath: frame assembly, checksum, commit, timeout, wipe.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        tmo_d        = tmo_q;
        stage_d      = stage_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        key_loaded_d = 1'b0;
        key_error_d  = 1'b0;

        if (key_clear && (state_q != S_LOCKED)) begin
            // Wipe wins over any commit/error in the same cycle.
            state_d     = S_IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            tmo_d       = '0;
            stage_d     = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        stage_d      = '0;
                        stage_d[7:0] = s_data;
                        acc_d        = s_data;
                        cnt_d        = CNT_W'(1);
                        tmo_d        = '0;
                        state_d      = (NBYTES == 1) ? S_CHK : S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (cnt_q == CNT_W'(b)) begin
                                stage_d[8*b +: 8] = s_data;
                            end
                        end
                        acc_d = acc_q ^ s_data;
                        tmo_d = '0;
                        if (cnt_q == CNT_W'(NBYTES - 1)) begin
                            cnt_d   = '0;
                            state_d = S_CHK;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        key_error_d = 1'b0 | 1'b1;
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        acc_d       = '0;
                        tmo_d       = '0;
                        stage_d     = '0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end

                S_CHK: begin
                    if (accept) begin
                        if (s_data == acc_q) begin
                            key_d        = stage_q;
                            key_valid_d  = 1'b1;
                            key_loaded_d = 1'b1;
                            state_d      = ONE_SHOT ? S_LOCKED : S_IDLE;
                        end else begin
                            key_error_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                        cnt_d   = '0;
                        acc_d   = '0;
                        tmo_d   = '0;
                        stage_d = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        key_error_d = 1'b1;
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        acc_d       = '0;
                        tmo_d       = '0;
                        stage_d     = '0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end

                default: begin
                    // LOCKED: only rst leaves this state.
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            tmo_q        <= '0;
            stage_q      <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            key_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            tmo_q        <= tmo_d;
            stage_q      <= stage_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            key_loaded_q <= key_loaded_d;
            key_error_q  <= key_error_d;
        end
    end

    assign key_out    = key_q;
    assign key_valid  = key_valid_q;
    assign key_loaded = key_loaded_q;
    assign key_error  = key_error_q;
    assign locked     = (state_q == S_LOCKED);

endmodule

// File: tb/tb_rll_key_loader.sv
// Testbench for rll_key_loader: two instances (reloadable and one-shot),
// both with a short timeout; expected results go through a scoreboard queue.
module tb_rll_key_loader;

    localparam int NB = 4;

    typedef struct {
        bit          err;
        logic [31:0] key;
        bit          valid;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0][7:0]  s_data;
    logic [1:0]       s_valid;
    logic [1:0]       s_ready;
    logic [1:0]       key_clear;
    logic [1:0][31:0] key_out;
    logic [1:0]       key_valid;
    logic [1:0]       key_loaded;
    logic [1:0]       key_error;
    logic [1:0]       locked;

    logic [1:0][31:0] model_key;
    logic [1:0]       model_valid;
    exp_t             sb[$];
    int               total;
    int               bad;

    rll_key_loader #(.KEY_WIDTH(32), .TIMEOUT(4), .ONE_SHOT(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .key_clear(key_clear[0]), .key_out(key_out[0]), .key_valid(key_valid[0]),
        .key_loaded(key_loaded[0]), .key_error(key_error[0]), .locked(locked[0])
    );

    rll_key_loader #(.KEY_WIDTH(32), .TIMEOUT(4), .ONE_SHOT(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .key_clear(key_clear[1]), .key_out(key_out[1]), .key_valid(key_valid[1]),
        .key_loaded(key_loaded[1]), .key_error(key_error[1]), .locked(locked[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse rst for one cycle; outputs are sampled at the negedge rst falls.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = '0;
        key_clear = '0;
        s_data = '0;
        @(negedge clk);
        rst = 1'b0;
        model_key = '0;
        model_valid = '0;
        sb.delete();
    endtask

    // Push the expected outcome of a frame whose checksum byte is csum.
    task automatic push_expect(input int d, input logic [31:0] key, input logic [7:0] csum);
        exp_t e;
        logic [7:0] x;
        x = key[7:0] ^ key[15:8] ^ key[23:16] ^ key[31:24];
        if (csum == x) begin
            model_key[d] = key;
            model_valid[d] = 1'b1;
            e.err = 1'b0;
        end else begin
            e.err = 1'b1;
        end
        e.key = model_key[d];
        e.valid = model_valid[d];
        sb.push_back(e);
    endtask

    // Drive a whole frame; leaves the checksum byte on the bus for one cycle.
    task automatic send_frame(input int d, input logic [31:0] key, input logic [7:0] csum, input int gap);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            s_data[d] = key[8*k +: 8];
            s_valid[d] = 1'b1;
            key_clear[d] = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                s_valid[d] = 1'b0;
            end
        end
        @(negedge clk);
        s_data[d] = csum;
        s_valid[d] = 1'b1;
        push_expect(d, key, csum);
    endtask

    // Wait (bounded) for a loaded/error pulse, pop the scoreboard and compare.
    task automatic check_result(input int d, input int exp_lat, input string name);
        exp_t e;
        int   lat;
        bit   seen;
        bit   got_err;
        seen = 1'b0;
        lat = 0;
        got_err = 1'b0;
        for (int i = 1; i <= exp_lat + 10 && !seen; i++) begin
            @(negedge clk);
            if (key_loaded[d] || key_error[d]) begin
                seen = 1'b1;
                lat = i;
                got_err = key_error[d];
            end
            s_valid[d] = 1'b0;
            key_clear[d] = 1'b0;
        end
        total++;
        if (!seen || sb.size() == 0) begin
            bad++;
            $display("FAIL %s_pulse: seen=%0d queued=%0d required seen=1", name, seen, sb.size());
            if (sb.size() != 0) sb.delete(0);
        end else begin
            e = sb.pop_front();
            total++;
            if (lat !== exp_lat) begin
                bad++;
                $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, exp_lat);
            end
            total++;
            if (got_err !== e.err) begin
                bad++;
                $display("FAIL %s_kind: got err=%0d, want err=%0d", name, got_err, e.err);
            end
            total++;
            if (key_out[d] !== e.key) begin
                bad++;
                $display("FAIL %s_key: got %h, want %h", name, key_out[d], e.key);
            end
            total++;
            if (key_valid[d] !== e.valid) begin
                bad++;
                $display("FAIL %s_valid: got %b, want %b", name, key_valid[d], e.valid);
            end
            @(negedge clk);
            total++;
            if (key_loaded[d] !== 1'b0 || key_error[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s_pulse_width: loaded=%b error=%b, want 0 0", name, key_loaded[d], key_error[d]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (key_out[d] !== 32'h0 || key_valid[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_key%0d: got key=%h valid=%b, want 0 0", d, key_out[d], key_valid[d]);
            end
            total++;
            if (key_loaded[d] !== 1'b0 || key_error[d] !== 1'b0 || locked[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags%0d: got loaded=%b error=%b locked=%b, want 0 0 0",
                         d, key_loaded[d], key_error[d], locked[d]);
            end
            total++;
            if (s_ready[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready%0d: got %b, want 1", d, s_ready[d]);
            end
        end
    endtask

    task automatic test_good_load();
        send_frame(0, 32'hDEADBEEF, 8'h22, 0);
        check_result(0, 1, "good_load");
    endtask

    task automatic test_bad_checksum();
        send_frame(0, 32'hDEADBEEF, 8'h23, 0);
        check_result(0, 1, "bad_csum");
    endtask

    task automatic test_gaps();
        send_frame(0, 32'hA5C3_1E77, 8'hA5 ^ 8'hC3 ^ 8'h1E ^ 8'h77, 3);
        check_result(0, 1, "gap_load");
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_data[0] = 8'h10 + 8'(k);
            s_valid[0] = 1'b1;
        end
        e.err = 1'b1;
        e.key = model_key[0];
        e.valid = model_valid[0];
        sb.push_back(e);
        check_result(0, 5, "timeout");
        total++;
        if (s_ready[0] !== 1'b1 || locked[0] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: ready=%b locked=%b, want 1 0", s_ready[0], locked[0]);
        end
        send_frame(0, 32'h0BAD_F00D, 8'h0B ^ 8'hAD ^ 8'hF0 ^ 8'h0D, 0);
        check_result(0, 1, "after_timeout");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [10];
        logic [31:0] ka, kb;
        int pulses;
        exp_t e;
        ka = 32'h0102_0304;
        kb = 32'hF0E1_D2C3;
        for (int k = 0; k < NB; k++) begin
            bytes[k] = ka[8*k +: 8];
            bytes[5+k] = kb[8*k +: 8];
        end
        bytes[4] = 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04;
        bytes[9] = 8'hF0 ^ 8'hE1 ^ 8'hD2 ^ 8'hC3;
        push_expect(0, ka, bytes[4]);
        push_expect(0, kb, bytes[9]);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (key_loaded[0] || key_error[0]) begin
                pulses++;
                e = sb.pop_front();
                total++;
                if (key_loaded[0] !== 1'b1 || key_out[0] !== e.key || (i != 5 && i != 10)) begin
                    bad++;
                    $display("FAIL b2b_commit: at step %0d loaded=%b key=%h, want loaded=1 key=%h at step 5 or 10",
                             i, key_loaded[0], key_out[0], e.key);
                end
            end
            s_valid[0] = (i < 10);
            s_data[0] = (i < 10) ? bytes[i] : 8'h00;
        end
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d commits, want 2", pulses);
            sb.delete();
        end
    endtask

    task automatic test_clear_race();
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            s_data[0] = 8'h40 + 8'(k);
            s_valid[0] = 1'b1;
        end
        @(negedge clk);
        s_data[0] = 8'h40 ^ 8'h41 ^ 8'h42 ^ 8'h43;
        s_valid[0] = 1'b1;
        key_clear[0] = 1'b1;
        #1;
        total++;
        if (s_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_ready: got %b, want 0", s_ready[0]);
        end
        @(negedge clk);
        s_valid[0] = 1'b0;
        key_clear[0] = 1'b0;
        model_key[0] = '0;
        model_valid[0] = 1'b0;
        total++;
        if (key_loaded[0] !== 1'b0 || key_error[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_pulse: loaded=%b error=%b, want 0 0", key_loaded[0], key_error[0]);
        end
        total++;
        if (key_out[0] !== model_key[0] || key_valid[0] !== model_valid[0]) begin
            bad++;
            $display("FAIL clear_key: key=%h valid=%b, want %h %b", key_out[0], key_valid[0], model_key[0], model_valid[0]);
        end
        send_frame(0, 32'h5566_7788, 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88, 0);
        check_result(0, 1, "after_clear");
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_data[0] = 8'hEE;
            s_valid[0] = 1'b1;
        end
        do_reset();
        send_frame(0, 32'hCAFE_F00D, 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, 0);
        check_result(0, 1, "mid_reset");
    endtask

    task automatic test_one_shot();
        int stray;
        send_frame(1, 32'h1234_5678, 8'h08, 0);
        check_result(1, 1, "one_shot");
        total++;
        if (locked[1] !== 1'b1 || s_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL one_shot_lock: locked=%b ready=%b, want 1 0", locked[1], s_ready[1]);
        end
        stray = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (key_loaded[1] || key_error[1]) stray++;
            s_data[1] = 8'h99;
            s_valid[1] = (i < 5);
            key_clear[1] = (i == 5);
        end
        @(negedge clk);
        key_clear[1] = 1'b0;
        total++;
        if (stray !== 0 || key_out[1] !== 32'h1234_5678 || key_valid[1] !== 1'b1 || locked[1] !== 1'b1) begin
            bad++;
            $display("FAIL one_shot_hold: pulses=%0d key=%h valid=%b locked=%b, want 0 12345678 1 1",
                     stray, key_out[1], key_valid[1], locked[1]);
        end
        do_reset();
        #1;
        total++;
        if (key_out[1] !== 32'h0 || s_ready[1] !== 1'b1 || locked[1] !== 1'b0) begin
            bad++;
            $display("FAIL one_shot_reset: key=%h ready=%b locked=%b, want 0 1 0", key_out[1], s_ready[1], locked[1]);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        s_data = '0;
        s_valid = '0;
        key_clear = '0;
        model_key = '0;
        model_valid = '0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_gaps();
        test_timeout();
        test_back_to_back();
        test_clear_race();
        test_reset_mid_frame();
        test_one_shot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
